// File: rtl/rv_pkg.sv
// Shared RV32I front-end constants: architectural widths, reset PC and fetch FSM encoding.
// Pure declarations; no logic.
package rv_pkg;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from storage, so a push is visible next cycle.
// Push while full is accepted only together with a pop; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Pipelined instruction fetch: credit-limited memory requests, in-order responses into a prefetch FIFO.
// inst_* valid one cycle after a response; requests stall when outstanding+buffered would exceed DEPTH.
module rv_fetch_unit #(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter int              ADDR_W   = 14,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fetch_fault
);

  import rv_pkg::*;

  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W  = ((OUT_W > FCNT_W) ? OUT_W : FCNT_W) + 1;
  localparam int ENT_W  = ILEN + XLEN;

  logic [0:0]       state;
  logic             started;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_nxt;
  logic [OUT_W-1:0] discard;

  logic [ENT_W-1:0]  fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic credit_ok;
  logic req_fire;
  logic rsp_take;
  logic rsp_push;
  logic inst_pop;
  logic redirect_aligned;

  // Credit rule: every in-flight request already owns a FIFO slot.
  assign credit_ok = !fifo_full
                  && (outstanding < OUT_W'(MAX_OUT))
                  && ((SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));

  assign mem_req_valid    = started && (state == ST_FETCH) && credit_ok && !redirect_valid;
  assign mem_req_addr     = fetch_pc[ADDR_W-1:0];
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // A response with nothing outstanding is stale (e.g. from before reset) and is ignored.
  assign rsp_take = mem_rsp_valid && (outstanding != '0);
  assign rsp_push = rsp_take && (discard == '0) && !redirect_valid;

  assign inst_valid  = (state == ST_FETCH) && !fifo_empty;
  assign inst_pop    = inst_valid && inst_ready;
  assign inst_data   = fifo_head[ENT_W-1 -: ILEN];
  assign inst_pc     = fifo_head[XLEN-1:0];
  assign fetch_fault = (state == ST_FAULT);

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !rsp_take)      outstanding_nxt = outstanding + OUT_W'(1);
    else if (!req_fire && rsp_take) outstanding_nxt = outstanding - OUT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // Everything still in flight after this cycle belongs to the abandoned stream.
        discard  <= outstanding_nxt;
        state    <= redirect_aligned ? ST_FETCH : ST_FAULT;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (rsp_push) rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
        if (rsp_take && (discard != '0)) discard <= discard - OUT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_push),
    .push_data ({mem_rsp_data, rsp_pc}),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: random-latency memory model, expected-stream scoreboard and directed corner cases.
module tb_rv_fetch_unit;

  localparam int ADDR_W  = 14;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [31:0]       mem_rsp_data = '0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst_data;
  logic [31:0]       inst_pc;
  logic              fetch_fault;

  rv_fetch_unit #(
    .XLEN(32), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] exp_req_pc;
  logic [31:0] last_pc;
  bit          exp_fault;
  bit          seen_wrap;
  int total = 0, bad = 0;
  int cyc = 0, fires = 0, pops = 0, last_due = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {~a, 4'h5, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected output after reset/redirect: consecutive PCs from the target, data from the wrapped address.
  task automatic restart(input logic [31:0] pc);
    logic [31:0] p;
    exp_q.delete();
    exp_req_pc = pc;
    exp_fault  = (pc[1:0] != 2'b00);
    if (!exp_fault)
      for (int i = 0; i < 1024; i++) begin
        p = pc + 32'(4 * i);
        exp_q.push_back('{pc: p, data: mem_word(p[ADDR_W-1:0])});
      end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #2;
    restart(pc);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int start;
    int k;
    start = pops;
    k = 0;
    while ((pops - start) < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if ((pops - start) < n) begin
      bad++;
      $display("FAIL %s: got %0d handshakes, expected %0d within %0d cycles", name, pops - start, n, budget);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_fault", fetch_fault, 0);
    restart(RST_PC);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("first_req_after_release", mem_req_valid, 1);
  endtask

  // Memory: in-order responses, at most one per cycle, latency drawn per request.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_q.delete();
      last_due      = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
    end else begin
      mem_req_ready = ($urandom_range(99) < rdy_pct);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: checks request addresses and every decode handshake against the expected stream.
  always @(negedge clk) begin
    int   due;
    exp_t e;
    #2;
    if (reset_n) begin
      check("fault_flag", fetch_fault, exp_fault);
      if (exp_fault) begin
        check("fault_no_req", mem_req_valid, 0);
        check("fault_no_inst", inst_valid, 0);
      end
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_req_pc[ADDR_W-1:0]);
        if (exp_req_pc == 32'h0) seen_wrap = 1'b1;
        exp_req_pc += 32'd4;
        fires++;
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_q.push_back('{addr: mem_req_addr, due: due});
      end
      if (inst_valid && inst_ready) begin
        pops++;
        last_pc = inst_pc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst_unexpected: got pc %0h, expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
        end
      end
    end
  end

  initial begin
    int start;
    int k;
    bit faulted;
    logic [31:0] tgt;

    restart(RST_PC);
    tick();
    do_reset();

    // Streaming from reset with a single-cycle memory.
    inst_ready = 1'b1;
    wait_pops(8, 40, "startup_stream");

    // Decode stalled: exactly DEPTH requests accepted, then one more per freed slot.
    inst_ready = 1'b0;
    redirect(32'h8000_0040);
    start = fires;
    repeat (20) tick();
    check("stall_fire_count", fires - start, DEPTH);
    check("stall_req_valid", mem_req_valid, 0);
    check("stall_inst_valid", inst_valid, 1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("resume_req_valid", mem_req_valid, 1);
    repeat (10) tick();
    check("resume_fire_count", fires - start, DEPTH + 1);
    inst_ready = 1'b1;

    // Redirect with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (pend_q.size() < 2 && k < 20) begin tick(); k++; end
    check("two_outstanding", pend_q.size() >= 2, 1);
    redirect(32'h8000_0100);
    wait_pops(1, 30, "redirect_resume");
    check("redirect_first_pc", last_pc, 32'h8000_0100);

    // Redirect coinciding with a response and a head handshake.
    lat_min = 1;
    lat_max = 1;
    k = 0;
    while (!(mem_rsp_valid && inst_valid) && k < 50) begin tick(); k++; end
    check("rsp_and_head_seen", mem_rsp_valid && inst_valid, 1);
    redirect(32'h8000_0180);
    check("flush_empty_next", inst_valid, 0);
    wait_pops(1, 30, "flush_resume");
    check("flush_first_pc", last_pc, 32'h8000_0180);

    // Misaligned target halts fetch until an aligned redirect.
    redirect(32'h8000_0102);
    check("fault_set", fetch_fault, 1);
    start = fires;
    repeat (10) tick();
    check("fault_fire_count", fires - start, 0);
    redirect(32'h8000_0200);
    check("fault_cleared", fetch_fault, 0);
    wait_pops(1, 30, "fault_resume");
    check("fault_first_pc", last_pc, 32'h8000_0200);

    // PC and address wrap.
    seen_wrap = 1'b0;
    redirect(32'hFFFF_FFF8);
    wait_pops(4, 60, "wrap_stream");
    check("wrap_addr_seen", seen_wrap, 1);
    check("wrap_fourth_pc", last_pc, 32'h0000_0004);

    // Random traffic, random redirects and occasional faults.
    rdy_pct = 70;
    lat_min = 1;
    lat_max = 4;
    faulted = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(99) < 70);
      if (faulted && $urandom_range(9) == 0) begin
        tgt = {16'h8000, 14'($urandom), 2'b00};
        redirect(tgt);
        faulted = 1'b0;
      end else if (!faulted && $urandom_range(39) == 0) begin
        tgt = {16'h8000, 14'($urandom), 2'($urandom)};
        if ($urandom_range(4) != 0) tgt[1:0] = 2'b00;
        redirect(tgt);
        faulted = (tgt[1:0] != 2'b00);
      end else begin
        tick();
      end
    end
    if (faulted) redirect(32'h8000_0300);

    // Reset in the middle of a burst.
    inst_ready = 1'b1;
    lat_min = 2;
    lat_max = 2;
    repeat (6) tick();
    do_reset();
    wait_pops(6, 60, "post_reset_stream");
    check("post_reset_pc", last_pc, RST_PC + 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
